// File: rtl/spi_ram_burst.sv
// spi_ram_burst: command-driven word RAM with independent write and read
// pointers. Each accepted command word carries a 2-bit opcode and a payload:
//   00 load write pointer   01 write payload at write pointer
//   10 load read pointer    11 read word at read pointer into dout
// Reads have one cycle of latency and are held in dout under tx_valid/tx_ready
// flow control. Back-to-back reads run at full rate while the consumer keeps
// tx_ready high.
module spi_ram_burst #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 2 ** ADDR_W,
  parameter int AUTO_INC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [ADDR_W-1:0] rd_addr_o
);

  // Width of a physical RAM index. The pointers are ADDR_W wide but are
  // always kept below MEM_DEPTH, so only the low IDX_W bits address memory.
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    OP_SET_WR = 2'b00,
    OP_WRITE  = 2'b01,
    OP_SET_RD = 2'b10,
    OP_READ   = 2'b11
  } opcode_e;

  // Storage is never reset; contents are undefined until written.
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0] dout_q;

  opcode_e           op;
  logic [DATA_W-1:0] payload;
  logic              accept;
  logic              wr_en;
  logic              rd_en;

  // A loaded address that lies beyond the memory wraps modulo its depth.
  function automatic logic [ADDR_W-1:0] wrap_load(input logic [ADDR_W-1:0] a);
    return ADDR_W'(int'({1'b0, a}) % MEM_DEPTH);
  endfunction

  // Post-increment that wraps from the last physical word back to zero,
  // which matters when MEM_DEPTH is smaller than 2**ADDR_W.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  assign op       = opcode_e'(din[DATA_W+1:DATA_W]);
  assign payload  = din[DATA_W-1:0];

  // Ready whenever the output slot is empty or is being drained this cycle;
  // a stalled read therefore blocks every opcode, keeping command order.
  assign rx_ready = !tx_valid_q || tx_ready;
  assign accept   = rx_valid && rx_ready;

  // Decode the accepted command into pointer updates and RAM strobes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    if (accept) begin
      case (op)
        OP_SET_WR: wr_ptr_d = wrap_load(payload[ADDR_W-1:0]);
        OP_WRITE: begin
          wr_en = 1'b1;
          if (AUTO_INC != 0) wr_ptr_d = next_addr(wr_ptr_q);
        end
        OP_SET_RD: rd_ptr_d = wrap_load(payload[ADDR_W-1:0]);
        OP_READ: begin
          rd_en = 1'b1;
          if (AUTO_INC != 0) rd_ptr_d = next_addr(rd_ptr_q);
        end
        default: ;
      endcase
    end
  end

  // Output slot: a new read refills it even while the old word is consumed;
  // otherwise a consumed word empties it.
  always_comb begin
    tx_valid_d = tx_valid_q;
    if (rd_en) begin
      tx_valid_d = 1'b1;
    end else if (tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  // Pointer and handshake state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // RAM write port; commands seen while in reset must not touch memory.
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) begin
      mem[wr_ptr_q[IDX_W-1:0]] <= payload;
    end
  end

  // Registered RAM read port feeding dout. A write and a read of the same
  // address can never share a cycle (one command per cycle), so a read that
  // follows a write always sees the freshly written word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (rd_en) begin
      dout_q <= mem[rd_ptr_q[IDX_W-1:0]];
    end
  end

  assign dout      = dout_q;
  assign tx_valid  = tx_valid_q;
  assign wr_addr_o = wr_ptr_q;
  assign rd_addr_o = rd_ptr_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst. One instance runs with address
// auto-increment, a second with the address held; each scenario task drives
// its own stimulus and checks against hand-computed values.
module tb_spi_ram_burst;

  localparam logic [1:0] OP_SWR = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_SRD = 2'b10;
  localparam logic [1:0] OP_RD  = 2'b11;

  logic       clk = 1'b0;
  integer     n_cmp = 0;
  integer     n_bad = 0;

  // Instance with AUTO_INC=1
  logic       rst_n = 1'b0;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] dout;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] wr_addr_o;
  logic [7:0] rd_addr_o;

  // Instance with AUTO_INC=0
  logic       n_rst_n = 1'b0;
  logic [9:0] n_din = '0;
  logic       n_rx_valid = 1'b0;
  logic       n_rx_ready;
  logic [7:0] n_dout;
  logic       n_tx_valid;
  logic       n_tx_ready = 1'b1;
  logic [7:0] n_wr_addr_o;
  logic [7:0] n_rd_addr_o;

  always #5 clk = ~clk;

  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .dout(dout), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wr_addr_o(wr_addr_o), .rd_addr_o(rd_addr_o)
  );

  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(0)) dut_hold (
    .clk(clk), .rst_n(n_rst_n), .din(n_din), .rx_valid(n_rx_valid), .rx_ready(n_rx_ready),
    .dout(n_dout), .tx_valid(n_tx_valid), .tx_ready(n_tx_ready),
    .wr_addr_o(n_wr_addr_o), .rd_addr_o(n_rd_addr_o)
  );

  // Present one command for one edge; inputs change 1 time unit after the edge.
  task automatic send(input logic [1:0] op, input logic [7:0] pl);
    din = {op, pl};
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    $display("cmd op=%b payload=0x%02h wr=0x%02h rd=0x%02h", op, pl, wr_addr_o, rd_addr_o);
  endtask

  task automatic n_send(input logic [1:0] op, input logic [7:0] pl);
    n_din = {op, pl};
    n_rx_valid = 1'b1;
    @(posedge clk); #1;
    n_rx_valid = 1'b0;
    $display("hold cmd op=%b payload=0x%02h wr=0x%02h rd=0x%02h", op, pl, n_wr_addr_o, n_rd_addr_o);
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_cmp = n_cmp + 5;
    if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
    if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout got=0x%02h want=0x00", dout); end
    if (wr_addr_o !== 8'h00) begin n_bad++; $display("FAIL reset_wr_addr got=0x%02h want=0x00", wr_addr_o); end
    if (rd_addr_o !== 8'h00) begin n_bad++; $display("FAIL reset_rd_addr got=0x%02h want=0x00", rd_addr_o); end
    if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rx_ready got=%b want=1", rx_ready); end
    $display("reset done tx_valid=%b dout=0x%02h", tx_valid, dout);
  endtask

  task automatic test_basic();
    tx_ready = 1'b1;
    send(OP_SWR, 8'h10);
    send(OP_WR, 8'hA5);
    send(OP_SRD, 8'h10);
    send(OP_RD, 8'h00);
    n_cmp = n_cmp + 4;
    if (tx_valid !== 1'b1) begin n_bad++; $display("FAIL basic_tx_valid got=%b want=1", tx_valid); end
    if (dout !== 8'hA5) begin n_bad++; $display("FAIL basic_dout got=0x%02h want=0xa5", dout); end
    if (wr_addr_o !== 8'h11) begin n_bad++; $display("FAIL basic_wr_addr got=0x%02h want=0x11", wr_addr_o); end
    if (rd_addr_o !== 8'h11) begin n_bad++; $display("FAIL basic_rd_addr got=0x%02h want=0x11", rd_addr_o); end
    idle();
    n_cmp++;
    if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL basic_tx_clear got=%b want=0", tx_valid); end
    $display("basic read dout=0x%02h", dout);
  endtask

  task automatic test_burst();
    logic [7:0] exp_data [3];
    exp_data = '{8'h11, 8'h22, 8'h33};
    tx_ready = 1'b1;
    send(OP_SWR, 8'h00);
    send(OP_WR, 8'h11);
    send(OP_WR, 8'h22);
    send(OP_WR, 8'h33);
    send(OP_SRD, 8'h00);
    din = {OP_RD, 8'h00};
    rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp = n_cmp + 2;
      if (tx_valid !== 1'b1) begin n_bad++; $display("FAIL burst_tx_valid[%0d] got=%b want=1", i, tx_valid); end
      if (dout !== exp_data[i]) begin n_bad++; $display("FAIL burst_dout[%0d] got=0x%02h want=0x%02h", i, dout, exp_data[i]); end
      $display("burst beat %0d dout=0x%02h", i, dout);
    end
    rx_valid = 1'b0;
    n_cmp++;
    if (rd_addr_o !== 8'h03) begin n_bad++; $display("FAIL burst_rd_addr got=0x%02h want=0x03", rd_addr_o); end
    idle();
  endtask

  task automatic test_wrap();
    tx_ready = 1'b1;
    send(OP_SWR, 8'hFF);
    send(OP_WR, 8'h5A);
    n_cmp++;
    if (wr_addr_o !== 8'h00) begin n_bad++; $display("FAIL wrap_wr_mid got=0x%02h want=0x00", wr_addr_o); end
    send(OP_WR, 8'h6B);
    n_cmp++;
    if (wr_addr_o !== 8'h01) begin n_bad++; $display("FAIL wrap_wr_addr got=0x%02h want=0x01", wr_addr_o); end
    send(OP_SRD, 8'hFF);
    send(OP_RD, 8'h00);
    n_cmp++;
    if (dout !== 8'h5A) begin n_bad++; $display("FAIL wrap_mem255 got=0x%02h want=0x5a", dout); end
    send(OP_RD, 8'h00);
    n_cmp = n_cmp + 2;
    if (dout !== 8'h6B) begin n_bad++; $display("FAIL wrap_mem0 got=0x%02h want=0x6b", dout); end
    if (rd_addr_o !== 8'h01) begin n_bad++; $display("FAIL wrap_rd_addr got=0x%02h want=0x01", rd_addr_o); end
    idle();
  endtask

  task automatic test_backpressure();
    tx_ready = 1'b1;
    send(OP_SWR, 8'h40);
    send(OP_SRD, 8'hFF);
    tx_ready = 1'b0;
    send(OP_RD, 8'h00);
    n_cmp++;
    if (dout !== 8'h5A) begin n_bad++; $display("FAIL bp_first_dout got=0x%02h want=0x5a", dout); end
    din = {OP_WR, 8'h77};
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp = n_cmp + 4;
      if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL bp_rx_ready[%0d] got=%b want=0", i, rx_ready); end
      if (tx_valid !== 1'b1) begin n_bad++; $display("FAIL bp_tx_valid[%0d] got=%b want=1", i, tx_valid); end
      if (dout !== 8'h5A) begin n_bad++; $display("FAIL bp_dout[%0d] got=0x%02h want=0x5a", i, dout); end
      if (wr_addr_o !== 8'h40) begin n_bad++; $display("FAIL bp_wr_addr[%0d] got=0x%02h want=0x40", i, wr_addr_o); end
      $display("stall cycle %0d rx_ready=%b dout=0x%02h", i, rx_ready, dout);
      @(posedge clk);
    end
    #1;
    tx_ready = 1'b1;
    #1;
    n_cmp++;
    if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got=%b want=1", rx_ready); end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    n_cmp = n_cmp + 2;
    if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL bp_tx_clear got=%b want=0", tx_valid); end
    if (wr_addr_o !== 8'h41) begin n_bad++; $display("FAIL bp_wr_done got=0x%02h want=0x41", wr_addr_o); end
    send(OP_SRD, 8'h40);
    send(OP_RD, 8'h00);
    n_cmp++;
    if (dout !== 8'h77) begin n_bad++; $display("FAIL bp_readback got=0x%02h want=0x77", dout); end
    idle();
  endtask

  task automatic test_no_inc();
    n_tx_ready = 1'b1;
    n_rst_n = 1'b1;
    n_send(OP_SWR, 8'h04);
    n_send(OP_WR, 8'h3C);
    n_cmp++;
    if (n_wr_addr_o !== 8'h04) begin n_bad++; $display("FAIL hold_wr_addr got=0x%02h want=0x04", n_wr_addr_o); end
    n_send(OP_SRD, 8'h04);
    n_din = {OP_RD, 8'h00};
    n_rx_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp = n_cmp + 3;
      if (n_tx_valid !== 1'b1) begin n_bad++; $display("FAIL hold_tx_valid[%0d] got=%b want=1", i, n_tx_valid); end
      if (n_dout !== 8'h3C) begin n_bad++; $display("FAIL hold_dout[%0d] got=0x%02h want=0x3c", i, n_dout); end
      if (n_rd_addr_o !== 8'h04) begin n_bad++; $display("FAIL hold_rd_addr[%0d] got=0x%02h want=0x04", i, n_rd_addr_o); end
      $display("hold read %0d dout=0x%02h rd=0x%02h", i, n_dout, n_rd_addr_o);
    end
    n_rx_valid = 1'b0;
    idle();
  endtask

  task automatic test_reset_mid_read();
    tx_ready = 1'b1;
    send(OP_SWR, 8'h10);
    send(OP_SRD, 8'h10);
    tx_ready = 1'b0;
    send(OP_RD, 8'h00);
    n_cmp++;
    if (tx_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_tx_valid got=%b want=1", tx_valid); end
    rst_n = 1'b0;
    din = {OP_WR, 8'hEE};
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rx_valid = 1'b0;
    #1;
    n_cmp = n_cmp + 5;
    if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_tx_valid got=%b want=0", tx_valid); end
    if (dout !== 8'h00) begin n_bad++; $display("FAIL rst_dout got=0x%02h want=0x00", dout); end
    if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL rst_rx_ready got=%b want=1", rx_ready); end
    if (wr_addr_o !== 8'h00) begin n_bad++; $display("FAIL rst_wr_addr got=0x%02h want=0x00", wr_addr_o); end
    if (rd_addr_o !== 8'h00) begin n_bad++; $display("FAIL rst_rd_addr got=0x%02h want=0x00", rd_addr_o); end
    tx_ready = 1'b1;
    send(OP_SRD, 8'h10);
    send(OP_RD, 8'h00);
    n_cmp++;
    if (dout !== 8'hA5) begin n_bad++; $display("FAIL rst_mem_kept got=0x%02h want=0xa5", dout); end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_burst();
    test_wrap();
    test_backpressure();
    test_no_inc();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
